rr_arbiter: RTL

Round-robin arbiter that grants one of `NUM_REQ` requesters at a time and holds the grant until release or a hold limit. It presents the winner both as a binary index and as a one-hot vector. The binary index feeds the downstream binary-to-one-hot select and decode stages. The one-hot grant returns to the requesters.

---
 rtl/rr_arbiter_pkg.sv | 15 +
 rtl/rr_pick.sv | 36 +++
 rtl/rr_arbiter.sv | 95 +++++++++
 3 files changed

// File: rtl/rr_arbiter_pkg.sv
// Shared types and helpers for the round-robin arbiter.
// Holds the FSM state type and the index-width function.
package rr_arbiter_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } rr_state_t;

   // Keeps the width at least 1 so that NUM_REQ=2 and MAX_HOLD<=2 still work.
   function automatic int calc_idx_w(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/rr_pick.sv
// Rotating-priority picker: first set request at or above ptr,
// wrapping around, found by a double-width masked search.
module rr_pick
   import rr_arbiter_pkg::*;
#(
   parameter int NUM_REQ = 4,
   parameter int IDX_W   = calc_idx_w(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [IDX_W-1:0]   ptr,
   output logic               found,
   output logic [IDX_W-1:0]   idx
);

   logic [2*NUM_REQ-1:0] dbl;

   // Lower copy hides requesters below ptr; upper copy covers the wrap.
   always_comb begin
      dbl = {req, req};
      for (int j = 0; j < NUM_REQ; j++) begin
         if (j < int'(ptr)) dbl[j] = 1'b0;
      end
   end

   always_comb begin
      found = |req;
      idx   = '0;
      for (int j = 2*NUM_REQ-1; j >= 0; j--) begin
         if (dbl[j]) begin
            if (j >= NUM_REQ) idx = IDX_W'(j - NUM_REQ);
            else              idx = IDX_W'(j);
         end
      end
   end

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin arbiter with grant hold, hold limit and one idle
// bubble between grants; all outputs registered.
module rr_arbiter
   import rr_arbiter_pkg::*;
#(
   parameter int NUM_REQ  = 4,
   parameter int IDX_W    = calc_idx_w(NUM_REQ),
   parameter int MAX_HOLD = 8
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [NUM_REQ-1:0] req_i,
   output logic               gnt_valid_o,
   output logic [NUM_REQ-1:0] gnt_o,
   output logic [IDX_W-1:0]   gnt_idx_o
);

   localparam int CNT_W = calc_idx_w(MAX_HOLD);

   rr_state_t            state, state_n;
   logic [IDX_W-1:0]     ptr, ptr_n;
   logic [CNT_W-1:0]     cnt, cnt_n;
   logic [IDX_W-1:0]     idx_n;
   logic [NUM_REQ-1:0]   gnt_n;
   logic                 valid_n;
   logic                 pick_found;
   logic [IDX_W-1:0]     pick_idx;
   logic                 release_now;

   rr_pick #(
      .NUM_REQ (NUM_REQ),
      .IDX_W   (IDX_W)
   ) u_pick (
      .req   (req_i),
      .ptr   (ptr),
      .found (pick_found),
      .idx   (pick_idx)
   );

   assign release_now = !req_i[gnt_idx_o] ||
                        (cnt == CNT_W'(MAX_HOLD - 1));

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= IDLE;
         ptr         <= '0;
         cnt         <= '0;
         gnt_idx_o   <= '0;
         gnt_o       <= '0;
         gnt_valid_o <= 1'b0;
      end else begin
         state       <= state_n;
         ptr         <= ptr_n;
         cnt         <= cnt_n;
         gnt_idx_o   <= idx_n;
         gnt_o       <= gnt_n;
         gnt_valid_o <= valid_n;
      end
   end

   always_comb begin
      state_n = state;
      ptr_n   = ptr;
      cnt_n   = cnt;
      idx_n   = gnt_idx_o;
      gnt_n   = gnt_o;
      valid_n = gnt_valid_o;
      unique case (state)
         IDLE: begin
            if (pick_found) begin
               state_n = GRANT;
               idx_n   = pick_idx;
               gnt_n   = NUM_REQ'(1) << pick_idx;
               valid_n = 1'b1;
               cnt_n   = '0;
            end
         end
         GRANT: begin
            if (release_now) begin
               state_n = IDLE;
               gnt_n   = '0;
               valid_n = 1'b0;
               cnt_n   = '0;
               // Explicit wrap keeps ptr in range for non-power-of-2 sizes.
               if (gnt_idx_o == IDX_W'(NUM_REQ - 1)) ptr_n = '0;
               else ptr_n = gnt_idx_o + IDX_W'(1);
            end else begin
               cnt_n = cnt + CNT_W'(1);
            end
         end
         default: state_n = IDLE;
      endcase
   end

endmodule
